fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end of the pipelined RISC-V core. Owns the fetch PC, drives it to the combinational instruction memory, captures the returned word, and hands {pc, instruction} pairs to decode through a small FIFO with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'd0: fetch address after reset.
- DEPTH, 2: FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  the single clock domain; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_pc  out  32  address to instruction memory; equals the internal fetch PC `fpc`.
- imem_instr  in  32  combinational instruction word for imem_pc, valid in the same cycle.
- redirect_valid  in  1  flush and restart request from execute.
- redirect_pc  in  32  restart target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- halted  out  1  fetch stopped on a zero word; driven to 0 unless FETCH_HALT_ON_ZERO_EN is defined.

## Operation
- State consists of `fpc`, a FIFO of DEPTH {pc, instr} entries with read/write pointers and a count, and a `halted` flag.
- pop = out_valid & out_ready.
- push = !redirect_valid & !halted & (count < DEPTH | pop). On push, {fpc, imem_instr} is written and `fpc` advances by 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Full with no pop: no push, `fpc` holds, and imem_pc stays stable.
- Full with a pop in the same cycle: push and pop both occur, and count is unchanged.
- Redirect has priority over everything else:
  - The FIFO is cleared (count 0, pointers 0).
  - `fpc` is loaded with {redirect_pc[31:2], 2'b00}.
  - `halted` is cleared and no push occurs.
  - A pop in the same cycle still counts as accepted by decode. The entry is then discarded with the flush.
- out_pc and out_instr always show the head slot, even when out_valid=0. Their contents are don't-care when out_valid=0, except at reset.

## Timing
- Reset (asynchronous, immediate):
  - imem_pc = RESET_PC.
  - out_valid = 0, out_pc = 0, out_instr = 0, halted = 0.
  - All FIFO storage is cleared to 0.
- First edge after rst deasserts pushes RESET_PC. out_valid rises in the next cycle.
- Fetch-to-decode latency is 1 cycle. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Redirect asserted in cycle N:
  - Cycle N+1: out_valid = 0 and imem_pc = target.
  - Cycle N+2: out_valid = 1 with out_pc = target.
- rst asserted mid-stream: out_valid drops in the same cycle, and all pending entries are lost.
- out_valid depends only on registered state, never combinationally on out_ready or redirect_valid.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined:
  - A fetched word of 32'h00000000 is not pushed, and `halted` is set at that edge.
  - `fpc` holds at the zero word's address.
  - Entries already queued drain normally.
  - Only a redirect or rst clears `halted`.
- FETCH_HALT_ON_ZERO_EN undefined:
  - Zero words are pushed like any other word.
  - `halted` is tied to 0 and the halt logic is absent.

## Test plan
Memory image for all scenarios: 0 → 00a00513, 4 → 00108093, 8 → fea0cee3, all other addresses → 0. RESET_PC=0, DEPTH=2.

- Reset release with out_ready=1 → out_pc/out_instr = 0/00a00513, 4/00108093, 8/fea0cee3 on consecutive cycles starting the cycle after the first edge. No gaps or duplicates.
- out_ready=0 for 5 cycles after reset → count saturates at 2 (pc 0, 4), imem_pc holds at 8. Raising out_ready then yields 0, 4, 8 back to back.
- With out_ready=1, assert redirect_valid with redirect_pc=4 in the cycle out_pc=8 → out_valid=0 for one cycle, then out_pc=4 followed by 8. Nothing already queued appears after the redirect.
- Assert redirect with redirect_pc=0x6 → imem_pc=4 next cycle, and the next delivered out_pc=4.
- Let fetch run past 8 with FETCH_HALT_ON_ZERO_EN defined → halted=1 after the edge at imem_pc=12, out stream ends at pc 8, imem_pc stays 12, and a redirect to 0 clears halted. With FETCH_HALT_ON_ZERO_EN undefined → pc 12 / 00000000 is delivered and halted stays 0.
- Assert rst mid-stream while 2 entries are queued → out_valid=0 and imem_pc=0 in the same cycle. After release, delivery restarts at pc 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC and queues {pc, instr} pairs for decode.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN (stop fetching when an all-zero word is fetched).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic          pop, push, fetch_ok, halted_q;
  logic          unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign imem_pc   = fpc;
  assign out_valid = (count != '0);
  assign out_pc    = fifo_pc[rptr];
  assign out_instr = fifo_instr[rptr];
  assign pop       = out_valid & out_ready;
  assign fetch_ok  = !redirect_valid && !halted_q && ((count != DEPTH_C) || pop);

`ifdef FETCH_HALT_ON_ZERO_EN
  logic halt_set;

  // A zero word is consumed as a stop marker rather than queued.
  assign halt_set = fetch_ok && (imem_instr == 32'd0);
  assign push     = fetch_ok && (imem_instr != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (halt_set) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign push     = fetch_ok;
  assign halted_q = 1'b0;
`endif

  assign halted = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc   <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fpc   <= {redirect_pc[31:2], 2'b00};
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fpc  <= fpc + 32'd4;
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared only on reset; a flush just resets the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= 32'd0;
        fifo_instr[i] <= 32'd0;
      end
    end else if (push) begin
      fifo_pc[wptr]    <= fpc;
      fifo_instr[wptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, directed scenarios, random traffic.
// Honours FETCH_HALT_ON_ZERO_EN the same way as the design.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ent_t        mq[$];
  ent_t        dlog[$];
  logic [31:0] mfpc;
  logic        mhalt;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h00a00513;
      32'd4:   return 32'h00108093;
      32'd8:   return 32'hfea0cee3;
      default: return 32'h00000000;
    endcase
  endfunction

  assign imem_instr = memf(imem_pc);

  fetch_unit #(.RESET_PC(32'd0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    mfpc  = 32'd0;
    mhalt = 1'b0;
  endtask

  task automatic compare_model();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("imem_pc", imem_pc, mfpc);
    chk("halted", 32'(halted), 32'(mhalt));
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
  endtask

  // Called at a negedge: check current outputs, drive this cycle's inputs, advance model to next edge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic pop, can;
    logic [31:0] w;
    ent_t e;
    compare_model();
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pop = (mq.size() > 0) && rdy;
    if (pop) begin
      e.pc = out_pc; e.instr = out_instr;
      dlog.push_back(e);
    end
    if (rv) begin
      mq.delete();
      mfpc  = {rpc[31:2], 2'b00};
      mhalt = 1'b0;
    end else begin
      can = !mhalt && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (can) begin
        w = memf(mfpc);
`ifdef FETCH_HALT_ON_ZERO_EN
        if (w == 32'd0) begin
          mhalt = 1'b1;
        end else begin
          e.pc = mfpc; e.instr = w;
          mq.push_back(e);
          mfpc = mfpc + 32'd4;
        end
`else
        e.pc = mfpc; e.instr = w;
        mq.push_back(e);
        mfpc = mfpc + 32'd4;
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    dlog.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] pc, input logic [31:0] ins);
    if (dlog.size() > idx) begin
      chk({name, "_pc"}, dlog[idx].pc, pc);
      chk({name, "_instr"}, dlog[idx].instr, ins);
    end else begin
      chk({name, "_logsize"}, 32'(dlog.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rv;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    apply_reset();

    // Stream from reset
    repeat (4) cycle(1'b1, 1'b0, 32'd0);
    chk_log("stream0", 0, 32'd0, 32'h00a00513);
    chk_log("stream1", 1, 32'd4, 32'h00108093);
    chk_log("stream2", 2, 32'd8, 32'hfea0cee3);

    // Backpressure saturates the FIFO
    apply_reset();
    repeat (5) cycle(1'b0, 1'b0, 32'd0);
    chk("bp_imem_pc", imem_pc, 32'd8);
    chk("bp_out_pc", out_pc, 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk_log("bp0", 0, 32'd0, 32'h00a00513);
    chk_log("bp1", 1, 32'd4, 32'h00108093);
    chk_log("bp2", 2, 32'd8, 32'hfea0cee3);

    // Redirect while head is pc 8
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk("pre_redir_out_pc", out_pc, 32'd8);
    cycle(1'b1, 1'b1, 32'd4);
    chk("redir_valid0", 32'(out_valid), 32'd0);
    chk("redir_imem_pc", imem_pc, 32'd4);
    dlog.delete();
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk_log("redir0", 0, 32'd4, 32'h00108093);
    chk_log("redir1", 1, 32'd8, 32'hfea0cee3);

    // Unaligned redirect target
    cycle(1'b1, 1'b1, 32'h6);
    chk("unal_imem_pc", imem_pc, 32'd4);
    dlog.delete();
    repeat (2) cycle(1'b1, 1'b0, 32'd0);
    chk_log("unal0", 0, 32'd4, 32'h00108093);

    // Run into the zero word
    apply_reset();
    repeat (6) cycle(1'b1, 1'b0, 32'd0);
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_imem_pc", imem_pc, 32'd12);
    chk("halt_logsize", 32'(dlog.size()), 32'd3);
    chk("halt_valid", 32'(out_valid), 32'd0);
`else
    chk("nohalt_flag", 32'(halted), 32'd0);
    chk_log("zero_word", 3, 32'd12, 32'h00000000);
`endif
    cycle(1'b1, 1'b1, 32'd0);
    chk("halt_cleared", 32'(halted), 32'd0);
    chk("halt_redir_pc", imem_pc, 32'd0);

    // Reset mid-stream with two entries queued
    apply_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk_log("post_rst0", 0, 32'd0, 32'h00a00513);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        rv = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
          0:       rpc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
          default: rpc = 32'($urandom_range(0, 15));
        endcase
        cycle($urandom_range(0, 9) < 7, rv, rpc);
      end
    end
    compare_model();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

endmodule
